// File: rtl/cache_pkg.sv
// Shared definitions for the sram_like -> AXI3 bridges and the future dcache.
package cache_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  // Fixed AXI3 attributes for single-beat transfers
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] LEN_SINGLE = 4'd0;

  // Byte-lane strobe for an access of the given size at the given byte offset.
  // Size 3 is not a legal sram_like size; it is treated as a full word.
  function automatic logic [3:0] size_addr_to_strb(input logic [1:0] size,
                                                    input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr;
      2'd1:    strb = 4'b0011 << {addr[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/d_sram_like2axi.sv
// Data-side sram_like to single-beat AXI3 master bridge.
// One transaction in flight at a time; a request is only accepted in IDLE.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for data_req_i; addr_ok mirrors the request
// RD_ADDR    | arvalid high until arready
// RD_DATA    | rready high; data_ok and rdata forwarded on rvalid
// WR_REQ     | awvalid/wvalid issued together, each dropped after its handshake
// WR_RESP    | bready high; data_ok forwarded on bvalid
module d_sram_like2axi
  import cache_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,

  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic [1:0]  arlock_o,
  output logic [3:0]  arcache_o,
  output logic [2:0]  arprot_o,
  output logic        arvalid_o,
  input  logic        arready_i,

  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,

  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic [1:0]  awlock_o,
  output logic [3:0]  awcache_o,
  output logic [2:0]  awprot_o,
  output logic        awvalid_o,
  input  logic        awready_i,

  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,

  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_accept;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_fin;
  logic        w_w_fin;

  // Response ids/codes and rlast carry no information for a single-beat,
  // single-outstanding master; error responses complete like OKAY.
  logic        w_unused_resp;
  assign w_unused_resp = ^{rid_i, rresp_i, rlast_i, bid_i, bresp_i};

  assign w_accept = (r_state == ST_IDLE) && data_req_i;
  assign w_aw_hs  = awvalid_o && awready_i;
  assign w_w_hs   = wvalid_o && wready_i;
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done || w_w_hs;

  // sram_like side
  assign data_addr_ok_o = w_accept;
  assign data_data_ok_o = ((r_state == ST_RD_DATA) && rvalid_i) ||
                          ((r_state == ST_WR_RESP) && bvalid_i);
  assign data_rdata_o   = rdata_i;

  // AR channel
  assign arid_o    = AXI_ID;
  assign araddr_o  = r_addr;
  assign arlen_o   = LEN_SINGLE;
  assign arsize_o  = {1'b0, r_size};
  assign arburst_o = BURST_INCR;
  assign arlock_o  = 2'd0;
  assign arcache_o = 4'd0;
  assign arprot_o  = 3'd0;
  assign arvalid_o = (r_state == ST_RD_ADDR);

  // R channel
  assign rready_o  = (r_state == ST_RD_DATA);

  // AW channel
  assign awid_o    = AXI_ID;
  assign awaddr_o  = r_addr;
  assign awlen_o   = LEN_SINGLE;
  assign awsize_o  = {1'b0, r_size};
  assign awburst_o = BURST_INCR;
  assign awlock_o  = 2'd0;
  assign awcache_o = 4'd0;
  assign awprot_o  = 3'd0;
  assign awvalid_o = (r_state == ST_WR_REQ) && !r_aw_done;

  // W channel
  assign wid_o     = AXI_ID;
  assign wdata_o   = r_wdata;
  assign wstrb_o   = r_wstrb;
  assign wlast_o   = 1'b1;
  assign wvalid_o  = (r_state == ST_WR_REQ) && !r_w_done;

  // B channel
  assign bready_o  = (r_state == ST_WR_RESP);

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (data_req_i) w_state_nxt = data_wr_i ? ST_WR_REQ : ST_RD_ADDR;
      ST_RD_ADDR: if (arready_i)  w_state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (rvalid_i)   w_state_nxt = ST_IDLE;
      ST_WR_REQ:  if (w_aw_fin && w_w_fin) w_state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (bvalid_i)   w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Capture the request on acceptance; held stable for the whole transaction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr  <= 32'd0;
      r_size  <= 2'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_addr  <= data_addr_i;
      r_size  <= data_size_i;
      r_wdata <= data_wdata_i;
      r_wstrb <= size_addr_to_strb(data_size_i, data_addr_i[1:0]);
    end
  end

  // Track AW and W handshakes independently; clear once both are done
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == ST_WR_REQ) begin
      if (w_aw_fin && w_w_fin) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_d_sram_like2axi.sv
// Directed testbench for d_sram_like2axi.
module tb_d_sram_like2axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata_i;
  logic [31:0] rdata_o;
  logic        addr_ok, data_ok;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  d_sram_like2axi #(.AXI_ID(4'd1)) dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req), .data_wr_i(wr), .data_size_i(size),
    .data_addr_i(addr), .data_wdata_i(wdata_i), .data_rdata_o(rdata_o),
    .data_addr_ok_o(addr_ok), .data_data_ok_o(data_ok),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
    .arburst_o(arburst), .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot),
    .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
    .rvalid_i(rvalid), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
    .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot),
    .awvalid_o(awvalid), .awready_i(awready),
    .wid_o(wid), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast),
    .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  // Advance to just after the next rising edge; inputs are driven from here
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 0; wr = 0; size = 0; addr = 0; wdata_i = 0;
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    rid = 4'd3; rdata = 32'h1234_5678; rresp = 0; rlast = 1; bid = 4'd3; bresp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok});
    end
    total++;
    if ({araddr, wdata, wstrb, arsize} !== 71'd0) begin
      bad++;
      $display("FAIL reset_latched araddr=%h wdata=%h wstrb=%b arsize=%0d exp all 0",
               araddr, wdata, wstrb, arsize);
    end
    total++;
    if (rdata_o !== 32'h1234_5678) begin
      bad++; $display("FAIL reset_rdata_follow got=%h exp=12345678", rdata_o);
    end
    next();
    rst = 0;
  endtask

  task automatic test_word_read();
    req = 1; wr = 0; size = 2; addr = 32'h1FC0_0010;
    arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    @(negedge clk);
    total++;
    if ({addr_ok, data_ok} !== 2'b10) begin
      bad++; $display("FAIL rd_accept got=%b exp=10", {addr_ok, data_ok});
    end
    next(); req = 0; addr = 32'h0;
    @(negedge clk);
    total++;
    if ({arvalid, araddr, arsize, arlen, arburst, arid, arlock, arcache, arprot, data_ok, rready}
        !== {1'b1, 32'h1FC0_0010, 3'd2, 4'd0, 2'b01, 4'd1, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rd_ar got v=%b a=%h sz=%0d len=%0d bu=%b id=%0d ok=%b rr=%b exp v=1 a=1fc00010 sz=2 len=0 bu=01 id=1 ok=0 rr=0",
               arvalid, araddr, arsize, arlen, arburst, arid, data_ok, rready);
    end
    next();
    @(negedge clk);
    total++;
    if ({rready, data_ok, addr_ok, arvalid} !== 4'b1100 || rdata_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rd_data got rr/ok/aok/arv=%b rdata=%h exp 1100 deadbeef",
               {rready, data_ok, addr_ok, arvalid}, rdata_o);
    end
    next(); rvalid = 0; arready = 0; rresp = 0;
    @(negedge clk);
    total++;
    if ({rready, data_ok} !== 2'b00) begin
      bad++; $display("FAIL rd_done got=%b exp=00", {rready, data_ok});
    end
    next();
  endtask

  task automatic test_byte_write();
    req = 1; wr = 1; size = 0; addr = 32'h1000_0003; wdata_i = 32'hAB00_0000;
    awready = 1; wready = 0; bvalid = 0;
    @(negedge clk);
    total++;
    if (addr_ok !== 1'b1) begin bad++; $display("FAIL bw_accept got=%b exp=1", addr_ok); end
    next(); req = 0; wdata_i = 0;
    @(negedge clk);
    total++;
    if ({awvalid, wvalid, wstrb, awaddr, awsize, wdata, wlast, wid, awid, bready}
        !== {1'b1, 1'b1, 4'b1000, 32'h1000_0003, 3'd0, 32'hAB00_0000, 1'b1, 4'd1, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL bw_issue got awv=%b wv=%b strb=%b a=%h sz=%0d wd=%h last=%b br=%b exp 1 1 1000 10000003 0 ab000000 1 0",
               awvalid, wvalid, wstrb, awaddr, awsize, wdata, wlast, bready);
    end
    next(); awready = 0;
    @(negedge clk);
    total++;
    if ({awvalid, wvalid, bready} !== 3'b010) begin
      bad++; $display("FAIL bw_aw_dropped got=%b exp=010", {awvalid, wvalid, bready});
    end
    next(); wready = 1;
    @(negedge clk);
    total++;
    if ({awvalid, wvalid, bready} !== 3'b010) begin
      bad++; $display("FAIL bw_w_held got=%b exp=010", {awvalid, wvalid, bready});
    end
    next(); wready = 0;
    @(negedge clk);
    total++;
    if ({awvalid, wvalid, bready, data_ok} !== 4'b0010) begin
      bad++; $display("FAIL bw_resp_wait got=%b exp=0010", {awvalid, wvalid, bready, data_ok});
    end
    next(); bvalid = 1; bresp = 2'b11;
    @(negedge clk);
    total++;
    if ({bready, data_ok} !== 2'b11) begin
      bad++; $display("FAIL bw_data_ok got=%b exp=11", {bready, data_ok});
    end
    next(); bvalid = 0; bresp = 0;
    @(negedge clk);
    total++;
    if ({bready, data_ok} !== 2'b00) begin
      bad++; $display("FAIL bw_done got=%b exp=00", {bready, data_ok});
    end
    next();
  endtask

  task automatic test_half_write();
    int ok_cnt;
    int wait_bad;
    ok_cnt = 0; wait_bad = 0;
    req = 1; wr = 1; size = 1; addr = 32'h2000_0002; wdata_i = 32'hBEEF_0000;
    awready = 1; wready = 1; bvalid = 0;
    @(negedge clk);
    next(); req = 0;
    @(negedge clk);
    total++;
    if ({awvalid, wvalid, wstrb, awsize} !== {1'b1, 1'b1, 4'b1100, 3'd1}) begin
      bad++;
      $display("FAIL hw_issue got awv=%b wv=%b strb=%b sz=%0d exp 1 1 1100 1",
               awvalid, wvalid, wstrb, awsize);
    end
    next(); awready = 0; wready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bready !== 1'b1 || data_ok !== 1'b0) wait_bad++;
      next();
    end
    total++;
    if (wait_bad !== 0) begin
      bad++; $display("FAIL hw_b_wait got=%0d bad cycles exp=0", wait_bad);
    end
    bvalid = 1;
    @(negedge clk);
    if (data_ok === 1'b1) ok_cnt++;
    next(); bvalid = 0;
    @(negedge clk);
    if (data_ok === 1'b1) ok_cnt++;
    total++;
    if (ok_cnt !== 1) begin
      bad++; $display("FAIL hw_data_ok_pulses got=%0d exp=1", ok_cnt);
    end
    next();
  endtask

  typedef struct {
    logic [1:0] sz;
    logic [1:0] lo;
    logic [3:0] strb;
  } strb_vec_t;

  task automatic test_strobes();
    strb_vec_t v[5];
    v[0] = '{2'd0, 2'd1, 4'b0010};
    v[1] = '{2'd0, 2'd2, 4'b0100};
    v[2] = '{2'd1, 2'd0, 4'b0011};
    v[3] = '{2'd2, 2'd3, 4'b1111};
    v[4] = '{2'd3, 2'd2, 4'b1111};
    awready = 1; wready = 1; bvalid = 1;
    for (int i = 0; i < 5; i++) begin
      req = 1; wr = 1; size = v[i].sz; addr = {30'h1800_0000, v[i].lo};
      wdata_i = 32'h0101_0101 * (i + 1);
      @(negedge clk);
      next(); req = 0;
      @(negedge clk);
      total++;
      if ({wstrb, awsize, awvalid} !== {v[i].strb, 1'b0, v[i].sz, 1'b1}) begin
        bad++;
        $display("FAIL strb_%0d got strb=%b sz=%0d awv=%b exp strb=%b sz=%0d awv=1",
                 i, wstrb, awsize, awvalid, v[i].strb, v[i].sz);
      end
      next();
      @(negedge clk);
      total++;
      if (data_ok !== 1'b1) begin
        bad++; $display("FAIL strb_%0d_done got=%b exp=1", i, data_ok);
      end
      next();
    end
    awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic test_back_to_back();
    int acc, dok, overlap, first_dok, second_acc, ar_hs, aw_hs, w_hs;
    acc = 0; dok = 0; overlap = 0; first_dok = -1; second_acc = -1;
    ar_hs = 0; aw_hs = 0; w_hs = 0;
    arready = 1; rvalid = 1; awready = 1; wready = 1; bvalid = 1;
    size = 2; addr = 32'h5000_0004; wdata_i = 32'h7777_8888; rdata = 32'h0BAD_F00D;
    for (int c = 0; c < 12; c++) begin
      req = (acc < 2);
      wr  = (acc >= 1);
      @(negedge clk);
      if (addr_ok === 1'b1) begin
        acc++;
        if (acc == 2) second_acc = c;
      end
      if (data_ok === 1'b1) begin
        dok++;
        if (dok == 1) first_dok = c;
      end
      if (addr_ok === 1'b1 && data_ok === 1'b1) overlap++;
      if (arvalid === 1'b1 && arready) ar_hs++;
      if (awvalid === 1'b1 && awready) aw_hs++;
      if (wvalid === 1'b1 && wready) w_hs++;
      next();
    end
    idle_inputs();
    total++;
    if (acc !== 2 || dok !== 2 || overlap !== 0) begin
      bad++; $display("FAIL b2b_counts got acc=%0d dok=%0d overlap=%0d exp 2 2 0", acc, dok, overlap);
    end
    total++;
    if (first_dok !== 2 || second_acc !== 3) begin
      bad++; $display("FAIL b2b_timing got first_dok=%0d second_acc=%0d exp 2 3", first_dok, second_acc);
    end
    total++;
    if (ar_hs !== 1 || aw_hs !== 1 || w_hs !== 1) begin
      bad++; $display("FAIL b2b_axi_txns got ar=%0d aw=%0d w=%0d exp 1 1 1", ar_hs, aw_hs, w_hs);
    end
  endtask

  task automatic test_arready_stall();
    int viol;
    viol = 0;
    req = 1; wr = 0; size = 2; addr = 32'h3000_0040;
    arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    total++;
    if (addr_ok !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b exp=1", addr_ok); end
    next(); addr = 32'h5555_5554;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (arvalid !== 1'b1 || araddr !== 32'h3000_0040 || addr_ok !== 1'b0 || data_ok !== 1'b0)
        viol++;
      next();
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL stall_stable got=%0d bad cycles exp=0", viol); end
    arready = 1; req = 0;
    @(negedge clk);
    next(); arready = 0;
    @(negedge clk);
    total++;
    if (data_ok !== 1'b1 || rdata_o !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL stall_release got ok=%b rdata=%h exp 1 cafef00d", data_ok, rdata_o);
    end
    next(); rvalid = 0;
    @(negedge clk);
    next();
  endtask

  task automatic test_reset_mid();
    req = 1; wr = 0; size = 2; addr = 32'h4000_0000; arready = 1; rvalid = 0;
    @(negedge clk);
    next(); req = 0;
    @(negedge clk);
    next(); arready = 0; rst = 1;
    @(negedge clk);
    total++;
    if (rready !== 1'b1) begin bad++; $display("FAIL mid_in_rd_data got=%b exp=1", rready); end
    next(); rst = 0;
    req = 1; wr = 1; size = 2; addr = 32'h4000_0008; wdata_i = 32'h1122_3344;
    awready = 1; wready = 1; bvalid = 1;
    @(negedge clk);
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, data_ok, addr_ok} !== 7'b0000001) begin
      bad++;
      $display("FAIL mid_after_reset got=%b exp=0000001",
               {arvalid, rready, awvalid, wvalid, bready, data_ok, addr_ok});
    end
    next(); req = 0;
    @(negedge clk);
    total++;
    if ({awvalid, wvalid, awaddr, wstrb, wdata} !== {1'b1, 1'b1, 32'h4000_0008, 4'b1111, 32'h1122_3344}) begin
      bad++;
      $display("FAIL mid_new_write got awv=%b wv=%b a=%h strb=%b wd=%h exp 1 1 40000008 1111 11223344",
               awvalid, wvalid, awaddr, wstrb, wdata);
    end
    next();
    @(negedge clk);
    total++;
    if (data_ok !== 1'b1) begin bad++; $display("FAIL mid_write_done got=%b exp=1", data_ok); end
    next(); idle_inputs();
    @(negedge clk);
    next();
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_half_write();
    test_strobes();
    test_back_to_back();
    test_arready_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_sram_like2axi.md
Name: d_sram_like2axi

Overview:
Data-side bridge from the sram_like bus to a single-beat AXI3 master. It sits directly downstream of the CPU data sram→sram_like adapter and upstream of the AXI crossbar/interconnect. It accepts one sram_like request at a time and issues it as one AXI read (AR/R) or write (AW/W/B) transaction. It returns a single-cycle data_ok pulse with read data or write completion.

Parameters:
AXI_ID, 4'd1, value driven on arid/awid/wid (data side; instruction bridge uses 0)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
data_req_i  in  1  sram_like request
data_wr_i  in  1  1=write, 0=read
data_size_i  in  2  0=byte, 1=half, 2=word
data_addr_i  in  32  byte address
data_wdata_i  in  32  write data, already lane-aligned
data_rdata_o  out  32  read data, valid with data_ok
data_addr_ok_o  out  1  request accepted
data_data_ok_o  out  1  transaction complete
arid_o/araddr_o/arlen_o/arsize_o/arburst_o/arlock_o/arcache_o/arprot_o/arvalid_o  out  4/32/4/3/2/2/4/3/1  AXI3 AR
arready_i  in  1
rid_i/rdata_i/rresp_i/rlast_i/rvalid_i  in  4/32/2/1/1  AXI3 R
rready_o  out  1
awid_o/awaddr_o/awlen_o/awsize_o/awburst_o/awlock_o/awcache_o/awprot_o/awvalid_o  out  4/32/4/3/2/2/4/3/1  AXI3 AW
awready_i  in  1
wid_o/wdata_o/wstrb_o/wlast_o/wvalid_o  out  4/32/4/1/1  AXI3 W
wready_i  in  1
bid_i/bresp_i/bvalid_i  in  4/2/1  AXI3 B
bready_o  out  1

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset → IDLE.
- Outputs after reset: all valid/ready/ok outputs 0; latched addr/size/wdata/wstrb 0; data_rdata_o follows rdata_i.
- IDLE: data_addr_ok_o = data_req_i (combinational). On req, latch addr, size, wdata and computed wstrb. Next state is RD_ADDR if wr=0, else WR_REQ. No acceptance in any other state.
- RD_ADDR: arvalid_o=1. On arready_i go to RD_DATA. araddr/arvalid stay stable until the handshake.
- RD_DATA: rready_o=1. data_data_ok_o = rvalid_i, data_rdata_o = rdata_i in the same cycle. On rvalid_i go to IDLE.
- WR_REQ: awvalid_o and wvalid_o rise together. Internal aw_done/w_done flags:
  - Each valid drops after its own handshake.
  - When both handshakes are done (same cycle or separately), go to WR_RESP and clear both flags.
- WR_RESP: bready_o=1. data_data_ok_o = bvalid_i. On bvalid_i go to IDLE.
- Minimum latency, req to data_ok:
  - Read: 3 cycles with arready and rvalid always high (IDLE→RD_ADDR→RD_DATA).
  - Write: 3 cycles with awready, wready and bvalid high.
- data_addr_ok_o and data_data_ok_o are never high in the same cycle. At most one outstanding transaction.
- Fixed AXI fields:
  - arlen/awlen=0, arburst/awburst=2'b01, lock=0, cache=0, prot=0.
  - size = {1'b0, latched size}; wlast=1; ids=AXI_ID.
  - araddr/awaddr = latched addr unmodified.
- wstrb:
  - size0 → 4'b0001 << addr[1:0].
  - size1 → 4'b0011 << {addr[1],1'b0}.
  - size2 → 4'b1111.
  - size3 (illegal) → 4'b1111.
- rresp/bresp/rid/bid/rlast are ignored. Error responses still produce data_ok.
- Reset mid-transaction: next edge returns to IDLE and drops all valids; the in-flight AXI transaction is abandoned (system-wide reset).
- data_req_i held high after data_ok: a new transaction is accepted the cycle the FSM is back in IDLE.

Decomposition:
- Shared package (cache_pkg):
  - state enum type.
  - AXI constants: BURST_INCR, LEN_SINGLE.
  - Pure function size_addr_to_strb(size, addr[1:0]), reused by the instruction bridge and the future dcache.
- No sub-module; single module.

Test Plan:
- Word read, addr 0x1FC0_0010: arready=1 the cycle after arvalid, rvalid with rdata 0xDEADBEEF on the next cycle → araddr=0x1FC0_0010, arsize=2, data_ok pulses once with rdata 0xDEADBEEF, 3 cycles after req.
- Byte write, addr 0x...03, wdata 0xAB000000, size 0: awready before wready (2-cycle gap) → wstrb=4'b1000, awvalid drops after its handshake while wvalid is held, bready only after both, data_ok on bvalid.
- Half write, addr 0x...02, AW and W accepted the same cycle, bvalid delayed 5 cycles → wstrb=4'b1100, data_ok exactly one cycle, aligned with bvalid.
- Back-to-back read then write with req held high → second addr_ok only after the first data_ok, never in the same cycle; exactly two AXI transactions issued.
- arready held low for 10 cycles → arvalid/araddr stable throughout, addr_ok not reasserted, no data_ok.
- rst_i asserted in RD_DATA → next cycle: all valids 0, rready 0, FSM in IDLE; the following req is accepted immediately.
